// File: rtl/ps2_pkg.sv
// Shared types and parameter limits for the PS/2 packet framer slice.
package ps2_pkg;

    // Framer FSM states.
    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } ps2_state_t;

    // Upper bound on bytes per packet.
    localparam int unsigned PKT_BYTES_MAX = 8;

    // Width of the inter-byte gap counter.
    localparam int unsigned GAP_W = 16;

endpackage : ps2_pkg

// File: rtl/ps2_gap_timer.sv
// Inter-byte gap counter with timeout compare.
// expired is combinational: it flags the cycle in which the count would
// reach limit, so the framer can act on the same edge as the increment.
module ps2_gap_timer
    import ps2_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             run,
    input  logic [GAP_W-1:0] limit,
    output logic             expired
);

    logic [GAP_W-1:0] count_q;
    logic [GAP_W:0]   count_inc;

    assign count_inc = {1'b0, count_q} + 1'b1;

    // A limit of zero disables the timeout entirely.
    always_comb begin
        expired = run && (limit != '0) && (count_inc >= {1'b0, limit});
    end

    // Count idle cycles; clear has priority over run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (run) begin
            count_q <= count_inc[GAP_W-1:0];
        end
    end

endmodule : ps2_gap_timer

// File: rtl/ps2_packet_framer.sv
// PS/2 packet framer: finds a sync byte, gathers PKT_BYTES bytes and
// presents each complete packet on out_bytes with a one-cycle done pulse.
// Partial packets stalled longer than TIMEOUT_CYC idle cycles are dropped.
module ps2_packet_framer
    import ps2_pkg::*;
#(
    parameter int unsigned PKT_BYTES   = 3,
    parameter int unsigned SYNC_BIT    = 3,
    parameter int unsigned TIMEOUT_CYC = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [7:0]             in,
    output logic                   done,
    output logic [8*PKT_BYTES-1:0] out_bytes,
    output logic                   timeout_err
);

    generate
        if (PKT_BYTES < 2 || PKT_BYTES > PKT_BYTES_MAX) begin : g_bad_pkt_bytes
            $error("ps2_packet_framer: PKT_BYTES out of range 2..8");
        end
        if (SYNC_BIT > 7) begin : g_bad_sync_bit
            $error("ps2_packet_framer: SYNC_BIT out of range 0..7");
        end
        if (TIMEOUT_CYC > 65535) begin : g_bad_timeout
            $error("ps2_packet_framer: TIMEOUT_CYC out of range 0..65535");
        end
    endgenerate

    localparam int unsigned      CW    = $clog2(PKT_BYTES);
    localparam logic [CW-1:0]    LAST  = CW'(PKT_BYTES - 1);
    localparam logic [GAP_W-1:0] LIMIT = GAP_W'(TIMEOUT_CYC);

    ps2_state_t              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [8*PKT_BYTES-1:0]  asm_q, asm_d;
    logic                    load;
    logic [CW-1:0]           load_idx;
    logic                    timeout_hit;
    logic                    sync_ok;
    logic                    gap_clear;
    logic                    gap_run;
    logic                    gap_expired;

    assign sync_ok = in[SYNC_BIT];

    // Idle cycles only count while a packet is partly assembled.
    assign gap_run   = (state_q == COLLECT) && !in_valid;
    assign gap_clear = (state_q != COLLECT) || in_valid || gap_expired;

    ps2_gap_timer u_gap_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (gap_clear),
        .run     (gap_run),
        .limit   (LIMIT),
        .expired (gap_expired)
    );

    // Next-state, byte-index and load-control decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load        = 1'b0;
        load_idx    = cnt_q;
        timeout_hit = 1'b0;
        unique case (state_q)
            SEARCH: begin
                if (in_valid && sync_ok) begin
                    load     = 1'b1;
                    load_idx = '0;
                    cnt_d    = CW'(1);
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    load = 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (gap_expired) begin
                    cnt_d       = '0;
                    timeout_hit = 1'b1;
                    state_d     = SEARCH;
                end
            end
            DONE: begin
                if (in_valid && sync_ok) begin
                    load     = 1'b1;
                    load_idx = '0;
                    cnt_d    = CW'(1);
                    state_d  = COLLECT;
                end else begin
                    cnt_d   = '0;
                    state_d = SEARCH;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = SEARCH;
            end
        endcase
    end

    // Assembly buffer with the incoming byte merged at its index.
    always_comb begin
        asm_d = asm_q;
        if (load) begin
            for (int unsigned k = 0; k < PKT_BYTES; k++) begin
                if (load_idx == CW'(k)) begin
                    asm_d[8*k +: 8] = in;
                end
            end
        end
    end

    // FSM state and byte index registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEARCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Assembly, output and timeout-flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            asm_q       <= '0;
            out_bytes   <= '0;
            timeout_err <= 1'b0;
        end else begin
            asm_q       <= asm_d;
            timeout_err <= timeout_hit;
            if (state_q == COLLECT && state_d == DONE) begin
                out_bytes <= asm_d;
            end
        end
    end

    assign done = (state_q == DONE);

endmodule : ps2_packet_framer

// File: tb/tb_ps2_packet_framer.sv
// Directed self-checking bench for ps2_packet_framer.
module tb_ps2_packet_framer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        in_valid = 1'b0;
    logic [7:0]  in = '0;
    logic        done;
    logic [23:0] out_bytes;
    logic        timeout_err;

    logic        in_valid4 = 1'b0;
    logic [7:0]  in4 = '0;
    logic        done4;
    logic [31:0] out_bytes4;
    logic        timeout_err4;

    int total = 0;
    int bad   = 0;
    logic both_seen = 1'b0;
    logic terr4_seen = 1'b0;
    logic done4_early = 1'b0;

    always #5 clk = ~clk;

    ps2_packet_framer #(.PKT_BYTES(3), .SYNC_BIT(3), .TIMEOUT_CYC(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in          (in),
        .done        (done),
        .out_bytes   (out_bytes),
        .timeout_err (timeout_err)
    );

    ps2_packet_framer #(.PKT_BYTES(4), .SYNC_BIT(7), .TIMEOUT_CYC(0)) dut4 (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid4),
        .in          (in4),
        .done        (done4),
        .out_bytes   (out_bytes4),
        .timeout_err (timeout_err4)
    );

    // Watch for done and timeout_err ever coinciding.
    always @(negedge clk) begin
        if (done && timeout_err) both_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in       = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in       = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send4(input logic [7:0] b);
        in_valid4 = 1'b1;
        in4       = b;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        in4       = '0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_done", 64'(done), 64'h0);
        check("rst_out", 64'(out_bytes), 64'h0);
        check("rst_terr", 64'(timeout_err), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single packet
        send(8'h08);
        send(8'h11);
        check("p1_done_early", 64'(done), 64'h0);
        send(8'h22);
        check("p1_done", 64'(done), 64'h1);
        check("p1_out", 64'(out_bytes), 64'h221108);
        idle(1);
        check("p1_done_clr", 64'(done), 64'h0);
        check("p1_out_hold", 64'(out_bytes), 64'h221108);

        // Non-sync bytes skipped in SEARCH
        send(8'h00);
        send(8'h07);
        send(8'h0F);
        send(8'hAA);
        check("p2_done_early", 64'(done), 64'h0);
        send(8'hBB);
        check("p2_done", 64'(done), 64'h1);
        check("p2_out", 64'(out_bytes), 64'hBBAA0F);
        idle(1);
        check("p2_done_clr", 64'(done), 64'h0);

        // Back-to-back packets, sync byte taken during DONE
        send(8'h08);
        send(8'h01);
        send(8'h02);
        check("b2b1_done", 64'(done), 64'h1);
        check("b2b1_out", 64'(out_bytes), 64'h020108);
        send(8'h18);
        check("b2b_gap1", 64'(done), 64'h0);
        send(8'h03);
        check("b2b_gap2", 64'(done), 64'h0);
        send(8'h04);
        check("b2b2_done", 64'(done), 64'h1);
        check("b2b2_out", 64'(out_bytes), 64'h040318);
        idle(1);

        // Timeout after 4 idle cycles
        send(8'h08);
        send(8'h01);
        idle(3);
        check("to_pre_terr", 64'(timeout_err), 64'h0);
        idle(1);
        check("to_terr", 64'(timeout_err), 64'h1);
        check("to_no_done", 64'(done), 64'h0);
        check("to_out_hold", 64'(out_bytes), 64'h040318);
        idle(1);
        check("to_terr_clr", 64'(timeout_err), 64'h0);
        send(8'h08);
        send(8'h05);
        send(8'h06);
        check("to_next_done", 64'(done), 64'h1);
        check("to_next_out", 64'(out_bytes), 64'h060508);
        idle(1);

        // Byte arriving on the would-be timeout cycle is accepted
        send(8'h08);
        idle(3);
        send(8'h15);
        check("edge_no_terr", 64'(timeout_err), 64'h0);
        idle(3);
        send(8'h26);
        check("edge_terr_clr", 64'(timeout_err), 64'h0);
        check("edge_done", 64'(done), 64'h1);
        check("edge_out", 64'(out_bytes), 64'h261508);
        idle(1);

        // Asynchronous reset mid-packet
        send(8'h08);
        #2;
        reset = 1'b0;
        #1;
        check("ar_done", 64'(done), 64'h0);
        check("ar_out", 64'(out_bytes), 64'h0);
        check("ar_terr", 64'(timeout_err), 64'h0);
        idle(2);
        check("ar_out_held", 64'(out_bytes), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        send(8'h01);
        send(8'h02);
        send(8'h09);
        send(8'h0A);
        check("ar_done_early", 64'(done), 64'h0);
        send(8'h0B);
        check("ar_pkt_done", 64'(done), 64'h1);
        check("ar_pkt_out", 64'(out_bytes), 64'h0B0A09);
        idle(1);

        // 4-byte packets, sync on bit 7, timeout disabled
        send4(8'h80);
        for (int b = 1; b < 4; b++) begin
            for (int i = 0; i < 100; i++) begin
                @(posedge clk);
                #1;
                if (timeout_err4) terr4_seen = 1'b1;
                if (done4) done4_early = 1'b1;
            end
            send4(8'(b));
        end
        check("w4_no_terr", 64'(terr4_seen), 64'h0);
        check("w4_no_early_done", 64'(done4_early), 64'h0);
        check("w4_done", 64'(done4), 64'h1);
        check("w4_out", 64'(out_bytes4), 64'h03020180);
        idle(1);
        check("w4_done_clr", 64'(done4), 64'h0);

        check("never_both", 64'(both_seen), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ps2_packet_framer
